// File: rtl/serializer_piso_4bit.sv
// Parallel-in / serial-out stage: takes one word per valid/ready handshake and shifts it out
// one bit per clock with a data qualifier, an end-of-word pulse and an optional idle gap.
module serializer_piso_4bit #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          IDLE_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
  localparam logic [7:0]      GapLast = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q;
  logic [CntW-1:0]  bit_cnt_q;
  logic [7:0]       gap_cnt_q;
  logic [WIDTH-1:0] shreg_q;

  logic             last_bit;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shreg_next;

  assign last_bit   = (state_q == StShift) && (bit_cnt_q == LastBit);
  // Ready is gated by reset so nothing can be accepted while the block is held.
  assign load_ready = rst && ((state_q == StIdle) || (last_bit && (GAP_CYCLES == 0)));
  assign accept     = load_valid && load_ready;

  // The first bit goes straight to ser_out; the shift register keeps only the remainder.
  assign first_bit  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign load_rest  = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
  assign next_bit   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_next = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      shreg_q   <= '0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else if (accept) begin
      state_q   <= StShift;
      bit_cnt_q <= '0;
      shreg_q   <= load_rest;
      ser_out   <= first_bit;
      ser_valid <= 1'b1;
      busy      <= 1'b1;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (state_q)
        StIdle: begin
          busy <= 1'b0;
        end
        StShift: begin
          if (!last_bit) begin
            ser_out   <= next_bit;
            shreg_q   <= shreg_next;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            word_done <= ((bit_cnt_q + 1'b1) == LastBit);
          end else begin
            bit_cnt_q <= '0;
            ser_out   <= IDLE_BIT;
            ser_valid <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state_q   <= StGap;
              gap_cnt_q <= '0;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            busy      <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q   <= StIdle;
          ser_out   <= IDLE_BIT;
          ser_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
